// File: rtl/stopwatch_lap_capture.sv
// Lap/split capture stage between the stopwatch counter and the 7-segment decoder.
// Freezes the display on a split time, stores laps in a small buffer and pages through them.
module stopwatch_lap_capture #(
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       live_ms_10,
  input  logic [5:0]       live_secs,
  input  logic [5:0]       live_mins,
  input  logic             running,
  input  logic             lap_pulse,
  input  logic             recall_pulse,
  input  logic             clear_pulse,
  output logic [6:0]       ms_10,
  output logic [5:0]       secs,
  output logic [5:0]       mins,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] lap_count,
  output logic [CNT_W-1:0] recall_idx,
  output logic             full
);

  // Buffer is sized to the full index range so lap_count/recall_idx index it without truncation.
  localparam int unsigned BUF_N = 1 << CNT_W;

  typedef struct packed {
    logic [6:0] ms_10;
    logic [5:0] secs;
    logic [5:0] mins;
  } lap_t;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    SPLIT  = 2'd1,
    RECALL = 2'd2
  } state_t;

  state_t           state, nxt_state;
  lap_t             split_q, nxt_split;
  lap_t             disp_q, nxt_disp;
  lap_t             live;
  lap_t             lap_buf [BUF_N];
  logic [CNT_W-1:0] nxt_cnt, nxt_idx;
  logic             wr_en;
  logic             has_room;

  assign live     = '{ms_10: live_ms_10, secs: live_secs, mins: live_mins};
  assign has_room = (lap_count < CNT_W'(LAP_DEPTH));

  // Next-state, counters and display source; priority clear > lap > recall.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = lap_count;
    nxt_idx   = recall_idx;
    nxt_split = split_q;
    wr_en     = 1'b0;
    if (clear_pulse) begin
      nxt_state = LIVE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else if (lap_pulse) begin
      if (running) begin
        nxt_split = live;
        if (has_room) begin
          wr_en   = 1'b1;
          nxt_cnt = lap_count + CNT_W'(1);
        end
        if (state != RECALL) nxt_state = SPLIT;
      end else if (state == SPLIT) begin
        nxt_state = LIVE;
      end
    end else if (recall_pulse) begin
      if (state == RECALL) begin
        if (recall_idx == lap_count - CNT_W'(1)) begin
          nxt_state = LIVE;
          nxt_idx   = '0;
        end else begin
          nxt_idx = recall_idx + CNT_W'(1);
        end
      end else if (lap_count != '0) begin
        nxt_state = RECALL;
        nxt_idx   = '0;
      end
    end

    case (nxt_state)
      SPLIT:   nxt_disp = nxt_split;
      RECALL:  nxt_disp = lap_buf[nxt_idx];
      default: nxt_disp = live;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LIVE;
      split_q    <= '0;
      disp_q     <= '0;
      lap_count  <= '0;
      recall_idx <= '0;
      full       <= 1'b0;
    end else begin
      state      <= nxt_state;
      split_q    <= nxt_split;
      disp_q     <= nxt_disp;
      lap_count  <= nxt_cnt;
      recall_idx <= nxt_idx;
      full       <= (nxt_cnt == CNT_W'(LAP_DEPTH));
    end
  end

  // Lap storage needs no reset; entries above lap_count are never shown.
  always_ff @(posedge clk) begin
    if (wr_en) lap_buf[lap_count] <= live;
  end

  assign ms_10 = disp_q.ms_10;
  assign secs  = disp_q.secs;
  assign mins  = disp_q.mins;
  assign mode  = 2'(state);

endmodule

// File: tb/tb_stopwatch_lap_capture.sv
// Directed bench for stopwatch_lap_capture: live/split/recall paging, full buffer,
// coincident pulses and asynchronous reset.
module tb_stopwatch_lap_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] live_ms_10;
  logic [5:0] live_secs;
  logic [5:0] live_mins;
  logic       running;
  logic       lap_pulse;
  logic       recall_pulse;
  logic       clear_pulse;
  logic [6:0] ms_10;
  logic [5:0] secs;
  logic [5:0] mins;
  logic [1:0] mode;
  logic [2:0] lap_count;
  logic [2:0] recall_idx;
  logic       full;

  int errors = 0;
  int checks = 0;

  stopwatch_lap_capture #(.LAP_DEPTH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .live_ms_10   (live_ms_10),
    .live_secs    (live_secs),
    .live_mins    (live_mins),
    .running      (running),
    .lap_pulse    (lap_pulse),
    .recall_pulse (recall_pulse),
    .clear_pulse  (clear_pulse),
    .ms_10        (ms_10),
    .secs         (secs),
    .mins         (mins),
    .mode         (mode),
    .lap_count    (lap_count),
    .recall_idx   (recall_idx),
    .full         (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int m10, input int s, input int m);
    chk({tag, ".ms_10"}, 32'(ms_10), 32'(m10));
    chk({tag, ".secs"},  32'(secs),  32'(s));
    chk({tag, ".mins"},  32'(mins),  32'(m));
  endtask

  task automatic chk_ctl(input string tag, input int md, input int cnt, input int idx, input int fl);
    chk({tag, ".mode"},       32'(mode),       32'(md));
    chk({tag, ".lap_count"},  32'(lap_count),  32'(cnt));
    chk({tag, ".recall_idx"}, 32'(recall_idx), 32'(idx));
    chk({tag, ".full"},       32'(full),       32'(fl));
  endtask

  task automatic set_live(input int m10, input int s, input int m);
    live_ms_10 = 7'(m10);
    live_secs  = 6'(s);
    live_mins  = 6'(m);
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic clr, input logic lap, input logic rcl);
    clear_pulse  = clr;
    lap_pulse    = lap;
    recall_pulse = rcl;
    step();
    clear_pulse  = 1'b0;
    lap_pulse    = 1'b0;
    recall_pulse = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    running = 1'b0;
    lap_pulse = 1'b0;
    recall_pulse = 1'b0;
    clear_pulse = 1'b0;
    set_live(0, 0, 0);
    step();
    step();
    reset = 1'b0;
    chk_disp("reset_init", 0, 0, 0);
    chk_ctl("reset_init", 0, 0, 0, 0);

    // Live pass-through with one-cycle latency
    set_live(34, 12, 5);
    step();
    chk_disp("live_a", 34, 12, 5);
    set_live(35, 12, 5);
    step();
    chk_disp("live_b", 35, 12, 5);

    // Lap with counter stopped is ignored in LIVE
    pulse(0, 1, 0);
    chk_ctl("lap_stopped_live", 0, 0, 0, 0);

    // Recall with no laps is ignored
    pulse(0, 0, 1);
    chk_ctl("recall_empty", 0, 0, 0, 0);

    // Split sequence
    running = 1'b1;
    set_live(37, 5, 0);
    pulse(0, 1, 0);
    chk_disp("split1", 37, 5, 0);
    chk_ctl("split1", 1, 1, 0, 0);
    set_live(50, 6, 0);
    step();
    chk_disp("split1_hold", 37, 5, 0);
    set_live(2, 9, 0);
    pulse(0, 1, 0);
    chk_disp("split2", 2, 9, 0);
    chk_ctl("split2", 1, 2, 0, 0);
    running = 1'b0;
    set_live(10, 10, 0);
    pulse(0, 1, 0);
    chk_disp("split_exit", 10, 10, 0);
    chk_ctl("split_exit", 0, 2, 0, 0);

    // Recall paging through two laps
    pulse(0, 0, 1);
    chk_disp("recall0", 37, 5, 0);
    chk_ctl("recall0", 2, 2, 0, 0);
    pulse(0, 0, 1);
    chk_disp("recall1", 2, 9, 0);
    chk_ctl("recall1", 2, 2, 1, 0);
    pulse(0, 0, 1);
    chk_disp("recall_end", 10, 10, 0);
    chk_ctl("recall_end", 0, 2, 0, 0);

    pulse(1, 0, 0);
    chk_ctl("clear", 0, 0, 0, 0);

    // Fill the buffer
    running = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_live(i, i, 0);
      pulse(0, 1, 0);
    end
    chk_disp("fill4", 4, 4, 0);
    chk_ctl("fill4", 1, 4, 0, 1);
    set_live(0, 0, 1);
    pulse(0, 1, 0);
    chk_disp("fill5_sat", 0, 0, 1);
    chk_ctl("fill5_sat", 1, 4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      pulse(0, 0, 1);
      chk_disp($sformatf("full_recall%0d", i), i + 1, i + 1, 0);
      chk_ctl($sformatf("full_recall%0d", i), 2, 4, i, 1);
    end
    set_live(7, 7, 7);
    pulse(0, 0, 1);
    chk_disp("full_recall_exit", 7, 7, 7);
    chk_ctl("full_recall_exit", 0, 4, 0, 1);

    // Capture while recalling stores only
    pulse(1, 0, 0);
    set_live(11, 1, 0);
    pulse(0, 1, 0);
    set_live(22, 2, 0);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    chk_disp("rc_enter", 11, 1, 0);
    set_live(33, 3, 0);
    pulse(0, 1, 0);
    chk_disp("rc_capture", 11, 1, 0);
    chk_ctl("rc_capture", 2, 3, 0, 0);
    pulse(0, 0, 1);
    chk_disp("rc_next1", 22, 2, 0);
    pulse(0, 0, 1);
    chk_disp("rc_next2", 33, 3, 0);
    chk_ctl("rc_next2", 2, 3, 2, 0);
    pulse(0, 0, 1);
    chk_ctl("rc_exit", 0, 3, 0, 0);

    // Coincident pulses
    pulse(1, 0, 0);
    set_live(44, 4, 0);
    pulse(0, 1, 0);
    chk_ctl("pre_clear_lap", 1, 1, 0, 0);
    pulse(1, 1, 0);
    chk_ctl("clear_lap", 0, 0, 0, 0);
    chk_disp("clear_lap", 44, 4, 0);
    set_live(55, 5, 0);
    pulse(0, 1, 1);
    chk_disp("lap_recall", 55, 5, 0);
    chk_ctl("lap_recall", 1, 1, 0, 0);

    // Asynchronous reset in the middle of RECALL
    pulse(0, 0, 1);
    chk_ctl("pre_reset", 2, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_disp("async_reset", 0, 0, 0);
    chk_ctl("async_reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    set_live(9, 8, 7);
    step();
    chk_disp("post_reset", 9, 8, 7);
    chk_ctl("post_reset", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
